// File: rtl/slt_share_pkg.sv
// Shared definitions for the shared less-than comparator.
// Provides the requester-ID width helper and the ID-to-one-hot converter.
package slt_share_pkg;

  // Upper bound on the number of requesters that onehot() can encode
  localparam int unsigned MAX_REQ = 32;

  // ID width for nreq requesters (at least one bit)
  function automatic int unsigned id_width(input int unsigned nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // One-hot vector with bit 'id' set; callers truncate to their requester count
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id);
    return MAX_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en_i          global enable; 0 forces no grant and holds the pointer
//   req_i         per-requester request flags
//   gnt_c_o       combinational one-hot grant
//   gnt_id_c_o    combinational encoded grant ID (valid when gnt_vld_c_o)
//   gnt_vld_c_o   combinational: some requester is granted this cycle
module rr_arbiter
  import slt_share_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_c_o,
  output logic [IW-1:0]   gnt_id_c_o,
  output logic            gnt_vld_c_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // First requesting index searching ptr, ptr+1, ... modulo NREQ
  always_comb begin : grant_search
    int unsigned idx;
    gnt_c_o     = '0;
    gnt_id_c_o  = '0;
    gnt_vld_c_o = 1'b0;
    idx         = 0;
    if (en_i) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_vld_c_o && req_i[IW'(idx)]) begin
          gnt_vld_c_o = 1'b1;
          gnt_id_c_o  = IW'(idx);
          gnt_c_o     = NREQ'(onehot(idx));
        end
      end
    end
  end

  // Pointer moves just past the winner; wraps explicitly for non-power-of-2 NREQ
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_c_o) begin
      ptr_d = (gnt_id_c_o == IW'(NREQ - 1)) ? '0 : gnt_id_c_o + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/slt_share_arbiter.sv
// Shared registered unsigned less-than comparator for NREQ requesters.
// One requester is granted per cycle (round robin); its result appears one
// cycle later on D_OUT, tagged by the one-hot R_OUT.
// Ports:
//   CLK, RST   clock, async active-low reset
//   EN         global enable; 0 freezes arbiter and pipeline
//   REQ        per-requester operand-valid flags
//   A_IN,B_IN  operand lanes, requester i at [i*N +: N]
//   GNT        combinational one-hot grant (sampled at the next rising edge)
//   R_OUT      registered one-hot result owner
//   D_OUT      registered result: 1 if A<B (unsigned), zero-extended
//   BUSY       registered: result valid in the output stage
module slt_share_arbiter
  import slt_share_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned NREQ = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*N-1:0] A_IN,
  input  logic [NREQ*N-1:0] B_IN,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   R_OUT,
  output logic [N-1:0]      D_OUT,
  output logic              BUSY
);

  localparam int unsigned IW = id_width(NREQ);

  logic [IW-1:0]   gnt_id;
  logic            gnt_vld;
  logic [N-1:0]    a_sel, b_sel;
  logic [NREQ-1:0] r_out_q, r_out_d;
  logic [N-1:0]    d_out_q, d_out_d;
  logic            busy_q, busy_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (CLK),
    .rst_n       (RST),
    .en_i        (EN),
    .req_i       (REQ),
    .gnt_c_o     (GNT),
    .gnt_id_c_o  (gnt_id),
    .gnt_vld_c_o (gnt_vld)
  );

  // Operand mux steered by the one-hot grant
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GNT[i]) begin
        a_sel = A_IN[i*N +: N];
        b_sel = B_IN[i*N +: N];
      end
    end
  end

  // Output stage: hold everything when disabled; D_OUT also holds on idle cycles
  always_comb begin
    r_out_d = r_out_q;
    d_out_d = d_out_q;
    busy_d  = busy_q;
    if (EN) begin
      r_out_d = gnt_vld ? GNT : '0;
      busy_d  = gnt_vld;
      if (gnt_vld) d_out_d = N'(a_sel < b_sel);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_q <= '0;
      d_out_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      r_out_q <= r_out_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
    end
  end

  assign R_OUT = r_out_q;
  assign D_OUT = d_out_q;
  assign BUSY  = busy_q;

  // gnt_id is consumed through GNT; keep it observable for the bench/debug
  logic unused_gnt_id;
  assign unused_gnt_id = ^gnt_id;

endmodule

// File: tb/tb_slt_share_arbiter.sv
// Randomized and directed bench for slt_share_arbiter against a behavioural model.
module tb_slt_share_arbiter;

  localparam int N    = 16;
  localparam int NREQ = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              EN;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*N-1:0] A_IN, B_IN;
  logic [NREQ-1:0]   GNT, R_OUT;
  logic [N-1:0]      D_OUT;
  logic              BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int              m_ptr;
  logic [NREQ-1:0] m_r;
  logic [N-1:0]    m_d;
  logic            m_busy;
  logic [NREQ-1:0] gnt_seen;

  slt_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .REQ   (REQ),
    .A_IN  (A_IN),
    .B_IN  (B_IN),
    .GNT   (GNT),
    .R_OUT (R_OUT),
    .D_OUT (D_OUT),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr  = 0;
    m_r    = '0;
    m_d    = '0;
    m_busy = 1'b0;
  endfunction

  // Winner from the rotating search, -1 if none
  function automatic int model_grant(input logic en, input logic [NREQ-1:0] req);
    if (!en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: drive, check GNT, clock, update model, check registered outputs
  task automatic step(input logic en, input logic [NREQ-1:0] req,
                      input logic [NREQ*N-1:0] a, input logic [NREQ*N-1:0] b);
    int g;
    logic [NREQ-1:0] eg;
    EN = en; REQ = req; A_IN = a; B_IN = b;
    #1;
    g  = model_grant(en, req);
    eg = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("gnt", 32'(GNT), 32'(eg));
    gnt_seen = GNT;
    @(posedge CLK);
    if (en) begin
      if (g >= 0) begin
        m_d    = (a[g*N +: N] < b[g*N +: N]) ? N'(1) : N'(0);
        m_r    = eg;
        m_busy = 1'b1;
        m_ptr  = (g + 1) % NREQ;
      end else begin
        m_r    = '0;
        m_busy = 1'b0;
      end
    end
    #1;
    chk("r_out", 32'(R_OUT), 32'(m_r));
    chk("d_out", 32'(D_OUT), 32'(m_d));
    chk("busy",  32'(BUSY),  32'(m_busy));
  endtask

  // Async reset between edges with a result pending
  task automatic reset_mid();
    RST = 1'b0;
    #1;
    model_reset();
    chk("rst_r_out", 32'(R_OUT), 32'd0);
    chk("rst_d_out", 32'(D_OUT), 32'd0);
    chk("rst_busy",  32'(BUSY),  32'd0);
    #1;
    RST = 1'b1;
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return N'(16'h8000);
      3:       return N'(16'h7FFF);
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [NREQ*N-1:0] ra, rb;
    RST = 1'b0; EN = 1'b0; REQ = '0; A_IN = '0; B_IN = '0;
    model_reset();
    #3;
    chk("init_r_out", 32'(R_OUT), 32'd0);
    chk("init_d_out", 32'(D_OUT), 32'd0);
    chk("init_busy",  32'(BUSY),  32'd0);
    chk("init_gnt",   32'(GNT),   32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Fairness: all requesting, grant rotates from requester 0
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1111, {16'd1, 16'd9, 16'd4, 16'd2}, {16'd5, 16'd3, 16'd4, 16'd8});
      chk("fair_gnt", 32'(gnt_seen), 32'(4'b0001 << (i % 4)));
    end

    // Single requester 2: 3<7 then 7<7
    step(1'b1, 4'b0100, {16'd0, 16'd3, 16'd0, 16'd0}, {16'd0, 16'd7, 16'd0, 16'd0});
    chk("single_gnt", 32'(gnt_seen), 32'(4'b0100));
    chk("single_lt",  32'(D_OUT),    32'd1);
    step(1'b1, 4'b0100, {16'd0, 16'd7, 16'd0, 16'd0}, {16'd0, 16'd7, 16'd0, 16'd0});
    chk("single_eq",  32'(D_OUT),    32'd0);

    // Skip and wrap from pointer 3
    step(1'b1, 4'b0011, '0, {16'd0, 16'd0, 16'd1, 16'd1});
    chk("wrap_gnt0", 32'(gnt_seen), 32'(4'b0001));
    step(1'b1, 4'b0011, '0, {16'd0, 16'd0, 16'd1, 16'd1});
    chk("wrap_gnt1", 32'(gnt_seen), 32'(4'b0010));

    // Enable freeze with R_OUT=0010 held
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0001, '0, '1);
      chk("frz_r_out", 32'(R_OUT), 32'(4'b0010));
      chk("frz_busy",  32'(BUSY),  32'd1);
    end
    step(1'b1, 4'b0001, '0, '1);
    chk("unfrz_gnt", 32'(gnt_seen), 32'(4'b0001));

    // Unsigned extremes on requester 0 (pointer now 1, only requester 0 asks)
    step(1'b1, 4'b0001, {48'd0, 16'hFFFF}, {48'd0, 16'h0000});
    chk("ext_ffff_0", 32'(D_OUT), 32'd0);
    step(1'b1, 4'b0001, {48'd0, 16'h0000}, {48'd0, 16'hFFFF});
    chk("ext_0_ffff", 32'(D_OUT), 32'd1);
    step(1'b1, 4'b0001, {48'd0, 16'h7FFF}, {48'd0, 16'h8000});
    chk("ext_7fff_8000", 32'(D_OUT), 32'd1);

    // Reset mid-stream with all requesting
    step(1'b1, 4'b1111, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd2, 16'd2, 16'd2, 16'd2});
    step(1'b1, 4'b1111, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd2, 16'd2, 16'd2, 16'd2});
    reset_mid();
    step(1'b1, 4'b1111, '0, '0);
    chk("post_rst_gnt", 32'(gnt_seen), 32'(4'b0001));

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i*N +: N] = rnd_op();
        rb[i*N +: N] = ($urandom_range(0, 3) == 0) ? ra[i*N +: N] : rnd_op();
      end
      step(($urandom_range(0, 7) != 0), NREQ'($urandom), ra, rb);
      if (c == 250) reset_mid();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
